// File: rtl/inst_fetch_responder.sv
// Instruction-side fetch responder: translates the fetch PC, reads two
// consecutive words from a 1-cycle synchronous SRAM and returns the pair.
module inst_fetch_responder #(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] MEM_BASE  = 32'h1FC0_0000,
  parameter int          MEM_WORDS = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_kill,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_inst0,
  output logic [31:0]       resp_inst1,
  output logic [31:0]       resp_pc,
  output logic [1:0]        resp_exc,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, RESP} state_t;

  localparam logic [31:0] WORDS = 32'(MEM_WORDS);

  state_t              state_q, state_d;
  logic [31:0]         phys, idx;
  logic                ade, adf, accept;
  logic [ADDR_W-1:0]   idx_q, idx_inc;
  logic                last_q;

  // kseg0/kseg1 fold onto the low 512 MB; everything else is used as-is.
  always_comb begin
    phys = (req_addr[31:30] == 2'b10) ? (req_addr & 32'h1FFF_FFFF) : req_addr;
    idx  = (phys - MEM_BASE) >> 2;
    ade  = |req_addr[1:0];
    adf  = (phys < MEM_BASE) || (idx >= WORDS);
  end

  assign idx_inc = idx_q + ADDR_W'(1);
  assign accept  = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    case (state_q)
      IDLE: begin
        req_ready = !req_kill;
        if (req_valid && !req_kill) begin
          if (!(ade || adf)) begin
            mem_en   = 1'b1;
            mem_addr = idx[ADDR_W-1:0];
            state_d  = RD1;
          end else begin
            state_d  = RESP;
          end
        end
      end
      RD1: begin
        // The word past the end of the SRAM is never fetched.
        mem_en   = !last_q;
        mem_addr = last_q ? '0 : idx_inc;
        state_d  = req_kill ? IDLE : RD2;
      end
      RD2: state_d = req_kill ? IDLE : RESP;
      RESP: begin
        resp_valid = !req_kill;
        if (req_kill || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Hold the SRAM and handshake quiet while reset is asserted.
    if (!reset) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_en     = 1'b0;
      mem_addr   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= 1'b0;
      resp_inst0 <= '0;
      resp_inst1 <= '0;
      resp_pc    <= '0;
      resp_exc   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          resp_pc <= req_addr;
          idx_q   <= idx[ADDR_W-1:0];
          last_q  <= (idx == WORDS - 32'd1);
          if (ade || adf) begin
            resp_exc   <= ade ? 2'b10 : 2'b01;
            resp_inst0 <= '0;
            resp_inst1 <= '0;
          end else begin
            resp_exc   <= 2'b00;
          end
        end
        RD1:     resp_inst0 <= mem_rdata;
        RD2:     resp_inst1 <= last_q ? 32'h0 : mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Bench for inst_fetch_responder: directed scenarios plus randomized fetches
// checked against an address-arithmetic reference model.
module tb_inst_fetch_responder;

  localparam logic [31:0] BASE  = 32'h1FC0_0000;
  localparam int          WORDS = 65536;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_kill = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready, resp_valid, mem_en;
  logic [31:0] resp_inst0, resp_inst1, resp_pc;
  logic [1:0]  resp_exc;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:WORDS-1];
  int vectors = 0, miscompares = 0, rd_cnt = 0;

  inst_fetch_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_kill(req_kill), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_inst0(resp_inst0), .resp_inst1(resp_inst1),
    .resp_pc(resp_pc), .resp_exc(resp_exc), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte offset from the SRAM base as a signed 64-bit quantity.
  task automatic model(input logic [31:0] a, output logic [1:0] exc,
                       output logic [31:0] i0, output logic [31:0] i1,
                       output int lat, output int nrd);
    longint phys, off, w;
    phys = (a[31:30] == 2'b10) ? longint'(a % 32'h2000_0000) : longint'(a);
    off  = phys - longint'(BASE);
    exc = 2'b00; i0 = '0; i1 = '0; lat = 1; nrd = 0;
    if (a % 4 != 0)                          exc = 2'b10;
    else if (off < 0 || off / 4 >= WORDS)    exc = 2'b01;
    else begin
      w   = off / 4;
      i0  = mem[w];
      i1  = (w == WORDS - 1) ? 32'h0 : mem[w + 1];
      nrd = (w == WORDS - 1) ? 1 : 2;
      lat = 3;
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int stall);
    logic [1:0] e; logic [31:0] i0, i1; int lat, nrd, n, base;
    logic [97:0] snap;
    model(a, e, i0, i1, lat, nrd);
    @(negedge clk); req_valid = 1'b1; req_addr = a; resp_ready = 1'b0;
    #1 chk("req_ready_idle", req_ready, 1);
    base = rd_cnt;
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); req_valid = 1'b0; n++; end while (!resp_valid && n < 10);
    chk("latency", n, lat);
    chk("resp_pc", resp_pc, a);
    chk("resp_inst0", resp_inst0, i0);
    chk("resp_inst1", resp_inst1, i1);
    chk("resp_exc", resp_exc, e);
    snap = {resp_pc, resp_inst0, resp_inst1, resp_exc};
    repeat (stall) begin
      @(negedge clk);
      chk("stall_valid", resp_valid, 1);
      chk("stall_hold", {resp_pc, resp_inst0, resp_inst1, resp_exc}, snap);
    end
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
    chk("after_xfer_valid", resp_valid, 0);
    chk("mem_reads", rd_cnt - base, nrd);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h3C08_BFC0;
    mem[1] = 32'h2508_0000;

    #1 chk("reset_outputs",
           {resp_valid, req_ready, mem_en, mem_addr, resp_inst0, resp_inst1, resp_pc, resp_exc}, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    fetch(32'hBFC0_0000, 5);          // boot pair with a long stall
    fetch(32'hBFC0_0002, 0);          // misaligned -> ADE
    fetch(32'h8000_0000, 0);          // below SRAM base -> ADF
    fetch(32'hBFC0_0000 + 4 * (WORDS - 1), 1);  // last word, nop second slot
    fetch(32'hBFC0_0000 + 4 * WORDS, 0);        // one past the end -> ADF
    fetch(32'hBFC0_0003 + 4 * WORDS, 0);        // both faults, ADE wins

    // Kill in RD1
    @(negedge clk); req_valid = 1'b1; req_addr = 32'hBFC0_0010;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0; req_kill = 1'b1;
    #1 chk("kill_rd1_valid", resp_valid, 0);
    @(negedge clk); req_kill = 1'b0;
    #1 chk("kill_idle_ready", req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("kill_no_resp", resp_valid, 0);
    end
    fetch(32'h9FC0_0004, 0);

    // Kill in IDLE blocks acceptance
    @(negedge clk); req_valid = 1'b1; req_kill = 1'b1; req_addr = 32'hBFC0_0000;
    #1 chk("kill_idle_ready0", req_ready, 0);
    chk("kill_idle_mem_en", mem_en, 0);
    @(negedge clk); req_valid = 1'b0; req_kill = 1'b0;
    #1 chk("kill_idle_still_idle", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("kill_idle_no_resp", resp_valid, 0);
    end

    // Kill in RESP wins over resp_ready
    @(negedge clk); req_valid = 1'b1; req_addr = 32'hBFC0_0008;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("kill_resp_valid_before", resp_valid, 1);
    req_kill = 1'b1; resp_ready = 1'b1;
    #1 chk("kill_resp_masked", resp_valid, 0);
    @(negedge clk); req_kill = 1'b0; resp_ready = 1'b0;
    #1 chk("kill_resp_idle", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("kill_resp_no_resp", resp_valid, 0);
    end

    // Reset asserted in RD2
    @(negedge clk); req_valid = 1'b1; req_addr = 32'hBFC0_0020;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    #1 chk("reset_mid_outputs",
           {resp_valid, req_ready, mem_en, mem_addr, resp_inst0, resp_inst1, resp_pc, resp_exc}, 0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk("reset_no_resp", resp_valid, 0);
    end

    // Randomized fetches across segments, alignments and range edges
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0: a = 32'hBFC0_0000 + 4 * $urandom_range(0, WORDS - 1);
        1: a = 32'h9FC0_0000 + 4 * $urandom_range(0, WORDS - 1);
        2: a = 32'h1FC0_0000 + 4 * $urandom_range(0, WORDS - 1);
        3: a = (32'hBFC0_0000 + 4 * $urandom_range(0, WORDS - 1)) | 32'($urandom_range(1, 3));
        4: a = $urandom;
        default: a = 32'hBFC0_0000 + 4 * (WORDS - 1 - $urandom_range(0, 1));
      endcase
      fetch(a, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
